ex_operand_ctrl: RTL and testbench
==================================

Name: ex_operand_ctrl

Overview:
- ID/EX pipeline-control stage of the 32-bit RISC-V pipelined core.
- Registers decoded register-address and control fields from ID into EX.
- Detects load-use hazards and generates the registered 2-bit select codes that steer the EX-stage four-input operand muxes (ALU A, ALU B, store data).
- Inserts bubbles on stall or flush, and keeps a saturating stall counter.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  ID source and destination registers
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1 / rs2
- id_reg_write, id_mem_read, id_mem_write  in  1  ID control bits
- id_a_is_pc, id_b_is_imm  in  1  ALU A takes PC; ALU B takes immediate
- exmem_rd  in  REG_ADDR_W  destination register in EX/MEM
- exmem_reg_write  in  1  EX/MEM writes a register
- flush  in  1  branch/jump taken; kill ID
- hold  in  1  global pipeline freeze (memory wait)
- stall  out  1  freeze PC and IF/ID (combinational)
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered EX control
- ex_rd  out  REG_ADDR_W  registered EX destination
- fwd_a_sel, fwd_b_sel, fwd_sd_sel  out  2  registered mux selects
- stall_cnt  out  CNT_W  load-use bubble count

Behaviour:
- Reset values: all registered outputs 0. Select outputs are 2'b00.
- Update priority on each edge: rst > flush > hold > load-use > normal.

Select encoding:
- 00: register file.
- 01: EX/MEM ALU result.
- 10: MEM/WB writeback value.
- 11: fwd_a_sel = PC, fwd_b_sel = immediate. Never driven on fwd_sd_sel.
- The register file is write-through, so no third forwarding level exists.

Select computation (in ID, latched into EX):
- The rs1 match is computed with priority, nearest producer first:
  - If id_uses_rs1, id_rs1 != 0, ex_valid, ex_reg_write and id_rs1 == ex_rd, the code is 01.
  - Otherwise, if id_uses_rs1, id_rs1 != 0, exmem_reg_write and id_rs1 == exmem_rd, the code is 10.
  - Otherwise 00.
- The rs2 match uses the same rule on rs2.
- fwd_a_sel = 11 if id_a_is_pc, else the rs1 match code.
- fwd_b_sel = 11 if id_b_is_imm, else the rs2 match code.
- fwd_sd_sel = the rs2 match code.

Load-use hazard:
- luh = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall = luh & ~flush & ~rst. stall is asserted independently of hold.

Per-edge register action:
- rst: everything cleared.
- flush: load a bubble. The bubble is all EX controls 0 and all selects 00. flush overrides hold.
- hold (no flush): all registers keep their value, including stall_cnt.
- luh: load a bubble and increment stall_cnt.
- Normal: load ID fields. ex_valid = id_valid, and control bits are ANDed with id_valid.

Timing and counter:
- Latency: one cycle from ID to EX outputs. stall has zero latency.
- The stalled instruction is re-presented the next cycle; its selects are then computed against the bubble (01 is not chosen) and the EX/MEM load (10).
- stall_cnt saturates at 2^CNT_W-1 and never wraps.
- rst mid-stall clears stall_cnt and the EX fields; stall drops in the reset cycle.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_ALT=2'b11.
  - REG_ADDR_W.
  - A bubble constant for the EX control bundle.
- One sub-module, fwd_match: purely combinational comparator returning the 2-bit match code for one source register. It is instantiated twice (rs1, rs2).

Test Plan:
- add x5 in EX (ex_reg_write=1, ex_rd=5), then ID add uses x5 as rs1 -> next edge fwd_a_sel=01, stall=0.
- exmem_rd=5 with exmem_reg_write=1, ex_rd=7, ID rs2=5, id_b_is_imm=0 -> fwd_b_sel=10, fwd_sd_sel=10; same with id_b_is_imm=1 -> fwd_b_sel=11, fwd_sd_sel=10.
- lw x6 in EX, ID uses rs1=6 -> stall=1; next edge ex_valid=0, stall_cnt=1; following cycle stall=0, fwd_a_sel=10 on re-presentation.
- Load-use with flush=1 in the same cycle -> stall=0, EX bubble loaded, stall_cnt unchanged; also rd=x0 matches -> all selects 00, no stall.
- hold=1 for 3 cycles with ex_valid=1, ex_rd=9 -> outputs frozen at 9/valid; hold+flush together -> bubble loaded.
- Force stall_cnt to 0xFFFF via repeated load-use -> stays 0xFFFF; assert rst during stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/ex_operand_ctrl_pkg.sv
// Shared definitions for the ID/EX operand control stage: select codes,
// register address width and the EX control bundle with its bubble value.
package ex_operand_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_ALT   = 2'b11;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/ex_operand_ctrl_fwd_match.sv
// Forwarding comparator for one source register: nearest producer (EX) wins
// over EX/MEM; x0 and unused sources always read the register file.
module fwd_match
  import ex_operand_ctrl_pkg::*;
#(
  parameter int ADDR_W = ex_operand_ctrl_pkg::REG_ADDR_W
) (
  input  logic              uses,
  input  logic [ADDR_W-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              exmem_reg_write,
  input  logic [ADDR_W-1:0] exmem_rd,
  output logic [1:0]        code
);

  always_comb begin
    code = FWD_RF;
    if (uses && (rs != '0)) begin
      if (ex_valid && ex_reg_write && (rs == ex_rd)) begin
        code = FWD_EXMEM;
      end else if (exmem_reg_write && (rs == exmem_rd)) begin
        code = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/ex_operand_ctrl.sv
// ID/EX control register: latches decoded fields into EX, detects load-use
// hazards, produces registered operand-mux selects and a saturating stall count.
module ex_operand_ctrl
  import ex_operand_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = ex_operand_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_a_is_pc,
  input  logic                  id_b_is_imm,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            fwd_sd_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_ctrl_t              ex_ctrl_p1;
  logic [REG_ADDR_W-1:0] ex_rd_p1;
  logic [1:0]            fwd_a_p1;
  logic [1:0]            fwd_b_p1;
  logic [1:0]            fwd_sd_p1;
  logic [CNT_W-1:0]      stall_cnt_p1;

  logic [1:0] rs1_code;
  logic [1:0] rs2_code;
  logic [1:0] fwd_a_p0;
  logic [1:0] fwd_b_p0;
  logic       luh;

  // ---- ID stage: forwarding match and hazard detection ----
  fwd_match #(.ADDR_W(REG_ADDR_W)) u_match_rs1 (
    .uses            (id_uses_rs1),
    .rs              (id_rs1),
    .ex_valid        (ex_ctrl_p1.valid),
    .ex_reg_write    (ex_ctrl_p1.reg_write),
    .ex_rd           (ex_rd_p1),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .code            (rs1_code)
  );

  fwd_match #(.ADDR_W(REG_ADDR_W)) u_match_rs2 (
    .uses            (id_uses_rs2),
    .rs              (id_rs2),
    .ex_valid        (ex_ctrl_p1.valid),
    .ex_reg_write    (ex_ctrl_p1.reg_write),
    .ex_rd           (ex_rd_p1),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .code            (rs2_code)
  );

  assign fwd_a_p0 = id_a_is_pc  ? FWD_ALT : rs1_code;
  assign fwd_b_p0 = id_b_is_imm ? FWD_ALT : rs2_code;

  assign luh = id_valid & ex_ctrl_p1.valid & ex_ctrl_p1.mem_read & (ex_rd_p1 != '0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd_p1)) | (id_uses_rs2 & (id_rs2 == ex_rd_p1)));

  // A taken branch kills the dependent instruction, so no stall is needed then.
  assign stall = luh & ~flush & ~rst;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_p1   <= EX_BUBBLE;
      ex_rd_p1     <= '0;
      fwd_a_p1     <= FWD_RF;
      fwd_b_p1     <= FWD_RF;
      fwd_sd_p1    <= FWD_RF;
      stall_cnt_p1 <= '0;
    end else if (flush) begin
      ex_ctrl_p1 <= EX_BUBBLE;
      ex_rd_p1   <= '0;
      fwd_a_p1   <= FWD_RF;
      fwd_b_p1   <= FWD_RF;
      fwd_sd_p1  <= FWD_RF;
    end else if (!hold) begin
      if (luh) begin
        ex_ctrl_p1 <= EX_BUBBLE;
        ex_rd_p1   <= '0;
        fwd_a_p1   <= FWD_RF;
        fwd_b_p1   <= FWD_RF;
        fwd_sd_p1  <= FWD_RF;
        if (stall_cnt_p1 != CNT_MAX) begin
          stall_cnt_p1 <= stall_cnt_p1 + 1'b1;
        end
      end else begin
        ex_ctrl_p1 <= '{valid:     id_valid,
                        reg_write: id_reg_write & id_valid,
                        mem_read:  id_mem_read  & id_valid,
                        mem_write: id_mem_write & id_valid};
        ex_rd_p1   <= id_rd;
        fwd_a_p1   <= fwd_a_p0;
        fwd_b_p1   <= fwd_b_p0;
        fwd_sd_p1  <= rs2_code;
      end
    end
  end

  // ---- EX stage outputs ----
  assign ex_valid     = ex_ctrl_p1.valid;
  assign ex_reg_write = ex_ctrl_p1.reg_write;
  assign ex_mem_read  = ex_ctrl_p1.mem_read;
  assign ex_mem_write = ex_ctrl_p1.mem_write;
  assign ex_rd        = ex_rd_p1;
  assign fwd_a_sel    = fwd_a_p1;
  assign fwd_b_sel    = fwd_b_p1;
  assign fwd_sd_sel   = fwd_sd_p1;
  assign stall_cnt    = stall_cnt_p1;

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Directed bench for ex_operand_ctrl: forwarding selects, load-use stalls,
// flush/hold priority, counter saturation and reset mid-stall.
module tb_ex_operand_ctrl;

  localparam int AW    = 5;
  localparam int CNT_W = 4;
  localparam logic [31:0] CNT_SAT = (32'd1 << CNT_W) - 32'd1;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic            id_a_is_pc, id_b_is_imm;
  logic [AW-1:0]   exmem_rd;
  logic            exmem_reg_write;
  logic            flush, hold;
  logic            stall;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [AW-1:0]   ex_rd;
  logic [1:0]      fwd_a_sel, fwd_b_sel, fwd_sd_sel;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  ex_operand_ctrl #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_a_is_pc      (id_a_is_pc),
    .id_b_is_imm     (id_b_is_imm),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .flush           (flush),
    .hold            (hold),
    .stall           (stall),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_rd           (ex_rd),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .fwd_sd_sel      (fwd_sd_sel),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic u1, input logic u2,
                        input logic rw, input logic mr, input logic mw);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = mw;
    id_a_is_pc   = 1'b0;
    id_b_is_imm  = 1'b0;
  endtask

  // Put lw x6 into EX, then present a consumer of x6 for one edge.
  task automatic do_luh();
    id_set(1, 0, 0, 6, 0, 0, 1, 1, 0);
    tick();
    id_set(1, 6, 0, 10, 1, 0, 1, 0, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    hold = 1'b0;
    exmem_rd = '0;
    exmem_reg_write = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_sel", {fwd_a_sel, fwd_b_sel, fwd_sd_sel}, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    // add x5 into EX, then a consumer of x5 on rs1
    id_set(1, 1, 2, 5, 1, 1, 1, 0, 0);
    tick();
    check("ex_load_valid", ex_valid, 1);
    check("ex_load_rd", ex_rd, 5);
    check("ex_load_rw", ex_reg_write, 1);
    id_set(1, 5, 0, 7, 1, 1, 1, 0, 0);
    #1 check("fwd_exmem_stall", stall, 0);
    tick();
    check("fwd_a_exmem", fwd_a_sel, 2'b01);
    check("fwd_b_x0", fwd_b_sel, 2'b00);

    // EX holds x7, EX/MEM holds x5: rs2=5 comes from MEM/WB path
    exmem_rd = 5;
    exmem_reg_write = 1'b1;
    id_set(1, 0, 5, 7, 0, 1, 1, 0, 0);
    tick();
    check("fwd_b_memwb", fwd_b_sel, 2'b10);
    check("fwd_sd_memwb", fwd_sd_sel, 2'b10);
    id_set(1, 0, 5, 7, 0, 1, 1, 0, 1);
    id_b_is_imm = 1'b1;
    tick();
    check("fwd_b_imm", fwd_b_sel, 2'b11);
    check("fwd_sd_imm", fwd_sd_sel, 2'b10);
    check("ex_mem_write", ex_mem_write, 1);
    // both EX (x7) and EX/MEM (x7) match: nearest wins; PC on A
    exmem_rd = 7;
    id_set(1, 7, 7, 8, 1, 1, 1, 0, 0);
    tick();
    check("fwd_a_priority", fwd_a_sel, 2'b01);
    check("fwd_sd_priority", fwd_sd_sel, 2'b01);
    id_set(1, 8, 0, 9, 1, 0, 1, 0, 0);
    id_a_is_pc = 1'b1;
    tick();
    check("fwd_a_pc", fwd_a_sel, 2'b11);
    id_set(0, 9, 0, 9, 1, 0, 1, 1, 1);
    tick();
    check("invalid_valid", ex_valid, 0);
    check("invalid_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    exmem_reg_write = 1'b0;

    // load-use on x6, then re-presentation picks MEM/WB
    id_set(1, 0, 0, 6, 0, 0, 1, 1, 0);
    tick();
    check("lw_mem_read", ex_mem_read, 1);
    id_set(1, 6, 0, 10, 1, 0, 1, 0, 0);
    #1 check("luh_stall", stall, 1);
    tick();
    check("luh_bubble", ex_valid, 0);
    check("luh_cnt", stall_cnt, 1);
    check("luh_bubble_sel", fwd_a_sel, 0);
    exmem_rd = 6;
    exmem_reg_write = 1'b1;
    #1 check("luh_stall_drop", stall, 0);
    tick();
    check("luh_repr_fwd", fwd_a_sel, 2'b10);
    check("luh_repr_valid", ex_valid, 1);
    check("luh_repr_rd", ex_rd, 10);
    check("luh_repr_cnt", stall_cnt, 1);
    exmem_reg_write = 1'b0;

    // load-use coinciding with flush
    id_set(1, 0, 0, 6, 0, 0, 1, 1, 0);
    tick();
    id_set(1, 6, 0, 10, 1, 0, 1, 0, 0);
    flush = 1'b1;
    #1 check("flush_stall", stall, 0);
    tick();
    check("flush_bubble", ex_valid, 0);
    check("flush_cnt", stall_cnt, 1);
    flush = 1'b0;

    // rd = x0 never forwards or stalls
    exmem_rd = 0;
    exmem_reg_write = 1'b1;
    id_set(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    id_set(1, 0, 0, 4, 1, 1, 1, 0, 0);
    #1 check("x0_stall", stall, 0);
    tick();
    check("x0_sel", {fwd_a_sel, fwd_b_sel, fwd_sd_sel}, 0);
    check("x0_valid", ex_valid, 1);
    exmem_reg_write = 1'b0;

    // hold freezes, hold+flush bubbles
    id_set(1, 1, 2, 9, 1, 1, 1, 0, 0);
    tick();
    hold = 1'b1;
    id_set(1, 3, 4, 3, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rd", ex_rd, 9);
      check("hold_valid", ex_valid, 1);
    end
    flush = 1'b1;
    tick();
    check("hold_flush_valid", ex_valid, 0);
    flush = 1'b0;
    hold = 1'b0;

    // load-use under hold: stall asserted, counter frozen
    id_set(1, 0, 0, 6, 0, 0, 1, 1, 0);
    tick();
    id_set(1, 0, 6, 10, 0, 1, 1, 0, 0);
    hold = 1'b1;
    #1 check("hold_luh_stall", stall, 1);
    tick();
    check("hold_luh_cnt", stall_cnt, 1);
    check("hold_luh_ex", ex_mem_read, 1);
    hold = 1'b0;
    tick();
    check("luh_rs2_cnt", stall_cnt, 2);

    // saturation
    for (int i = 0; i < 20; i++) do_luh();
    check("sat_cnt", stall_cnt, CNT_SAT);
    do_luh();
    check("sat_hold", stall_cnt, CNT_SAT);

    // reset in the middle of a stall
    id_set(1, 0, 0, 6, 0, 0, 1, 1, 0);
    tick();
    id_set(1, 6, 0, 10, 1, 0, 1, 0, 0);
    #1 check("rst_luh_stall", stall, 1);
    rst = 1'b1;
    #1 check("rst_stall_drop", stall, 0);
    tick();
    check("rst2_ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    check("rst2_rd", ex_rd, 0);
    check("rst2_sel", {fwd_a_sel, fwd_b_sel, fwd_sd_sel}, 0);
    check("rst2_cnt", stall_cnt, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
